// File: rtl/tile_rom_arbiter_pkg.sv
// Shared definitions for the tile/sprite colour ROM arbiter.
// Contents:
//   rgb332_t       - 8-bit RGB332 colour word as stored in the ROM
//   screen / tile  - tile edge length and active display window bounds
//   idx_w()        - width of an index into n items (minimum 1 bit)
package tile_rom_arbiter_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  localparam int unsigned TileSize     = 8;
  localparam int unsigned HActiveStart = 144;
  localparam int unsigned HActiveEnd   = 783;
  localparam int unsigned VActiveStart = 31;
  localparam int unsigned VActiveEnd   = 510;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_rom_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   mask   - candidate bits
//   ptr    - index where the search starts; wraps modulo N
//   onehot - first set mask bit at or after ptr, one-hot
//   found  - any mask bit set
module tile_rom_arbiter_rr_pick
  import tile_rom_arbiter_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic          found
);

  logic [IW-1:0] j;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    j      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = IW'((32'(ptr) + i) % N);
      if (!found && mask[j]) begin
        onehot[j] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Arbiter sharing one single-port colour ROM between pixel-path requesters.
// Class order: promoted (starved low-priority), high-priority, low-priority;
// round-robin within a class from one shared pointer.
// Ports:
//   clk, rst_n         - pixel clock, synchronous active-low reset
//   req, req_addr      - request levels and packed per-requester ROM addresses
//   gnt                - combinational one-hot grant
//   rom_en, rom_addr   - registered ROM read strobe and address
//   rom_dout           - ROM data, valid ROM_LAT cycles after rom_addr
//   rvalid, rdata      - registered read data, tagged one-hot to its requester
module tile_rom_arbiter
  import tile_rom_arbiter_pkg::*;
#(
  parameter int unsigned     NREQ       = 3,
  parameter int unsigned     ADDR_W     = 10,
  parameter int unsigned     DATA_W     = 8,
  parameter int unsigned     ROM_LAT    = 1,
  parameter logic [NREQ-1:0] HIPRI_MASK = 3'b001,
  parameter int unsigned     STARVE_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        gnt,
  output logic                   rom_en,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_dout,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata
);

  localparam int unsigned   IW     = idx_w(NREQ);
  localparam int unsigned   CW     = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CntMax = CW'(STARVE_MAX);

  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     cnt_q [NREQ];
  logic [CW-1:0]     cnt_d [NREQ];
  logic [NREQ-1:0]   promo;
  logic [NREQ-1:0]   mask_pro, mask_hi, mask_lo;
  logic [NREQ-1:0]   pick_pro, pick_hi, pick_lo;
  logic              found_pro, found_hi, found_lo;
  logic              any_gnt;
  logic [IW-1:0]     win_idx;
  logic [ADDR_W-1:0] win_addr;

  logic              rom_en_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ROM_LAT:0]  tag_vld_q;
  logic [IW-1:0]     tag_idx_q [ROM_LAT+1];
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Starvation counters exist only for low-priority requesters.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = '0;
      promo[i] = 1'b0;
      if (!HIPRI_MASK[i]) begin
        promo[i] = (cnt_q[i] == CntMax);
        if (!req[i] || gnt[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] != CntMax) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end
  end

  assign mask_pro = req & ~HIPRI_MASK & promo;
  assign mask_hi  = req & HIPRI_MASK;
  assign mask_lo  = req & ~HIPRI_MASK;

  tile_rom_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_pick_pro (
    .mask   (mask_pro),
    .ptr    (rr_ptr_q),
    .onehot (pick_pro),
    .found  (found_pro)
  );

  tile_rom_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_pick_hi (
    .mask   (mask_hi),
    .ptr    (rr_ptr_q),
    .onehot (pick_hi),
    .found  (found_hi)
  );

  tile_rom_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_pick_lo (
    .mask   (mask_lo),
    .ptr    (rr_ptr_q),
    .onehot (pick_lo),
    .found  (found_lo)
  );

  // Grant is suppressed while reset is asserted so nothing is issued that
  // the pipeline flush would then silently drop.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (found_pro) begin
        gnt = pick_pro;
      end else if (found_hi) begin
        gnt = pick_hi;
      end else if (found_lo) begin
        gnt = pick_lo;
      end
    end
  end

  always_comb begin
    any_gnt  = |gnt;
    win_idx  = '0;
    win_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_idx  = IW'(i);
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
    rr_ptr_d = any_gnt ? IW'((32'(win_idx) + 1) % NREQ) : rr_ptr_q;
  end

  // Tag stage ROM_LAT lines up with rom_dout being valid.
  always_comb begin
    rvalid_d = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rvalid_d[i] = tag_vld_q[ROM_LAT] && (tag_idx_q[ROM_LAT] == IW'(i));
    end
    rdata_d = tag_vld_q[ROM_LAT] ? rom_dout : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      cnt_q      <= '{default: '0};
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '{default: '0};
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      rom_en_q     <= any_gnt;
      rom_addr_q   <= any_gnt ? win_addr : rom_addr_q;
      tag_vld_q[0] <= any_gnt;
      tag_idx_q[0] <= win_idx;
      for (int unsigned i = 1; i <= ROM_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Directed bench: three arbiter builds share one stimulus stream.
//   dut_def - default parameters
//   dut_rr  - no high-priority class (pure round-robin)
//   dut_l3  - default mask, ROM_LAT = 3
module tb_tile_rom_arbiter;

  localparam logic [9:0] A0 = 10'h011;
  localparam logic [9:0] A1 = 10'h05A;
  localparam logic [9:0] A2 = 10'h3F0;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [29:0] req_addr;

  logic [2:0] gnt_def, gnt_rr, gnt_l3;
  logic       rom_en_def, rom_en_rr, rom_en_l3;
  logic [9:0] rom_addr_def, rom_addr_rr, rom_addr_l3;
  logic [7:0] dout_def, dout_rr, dout_l3;
  logic [2:0] rvalid_def, rvalid_rr, rvalid_l3;
  logic [7:0] rdata_def, rdata_rr, rdata_l3;
  logic [7:0] pipe_l3 [3];

  int checks;
  int failures;

  logic [2:0] exp_def [18];
  logic [2:0] exp_rr  [18];

  tile_rom_arbiter dut_def (
    .clk (clk), .rst_n (rst_n), .req (req), .req_addr (req_addr), .gnt (gnt_def),
    .rom_en (rom_en_def), .rom_addr (rom_addr_def), .rom_dout (dout_def),
    .rvalid (rvalid_def), .rdata (rdata_def)
  );

  tile_rom_arbiter #(.HIPRI_MASK(3'b000)) dut_rr (
    .clk (clk), .rst_n (rst_n), .req (req), .req_addr (req_addr), .gnt (gnt_rr),
    .rom_en (rom_en_rr), .rom_addr (rom_addr_rr), .rom_dout (dout_rr),
    .rvalid (rvalid_rr), .rdata (rdata_rr)
  );

  tile_rom_arbiter #(.ROM_LAT(3)) dut_l3 (
    .clk (clk), .rst_n (rst_n), .req (req), .req_addr (req_addr), .gnt (gnt_l3),
    .rom_en (rom_en_l3), .rom_addr (rom_addr_l3), .rom_dout (dout_l3),
    .rvalid (rvalid_l3), .rdata (rdata_l3)
  );

  function automatic logic [7:0] rom_f(input logic [9:0] a);
    return a[7:0] ^ 8'h99;
  endfunction

  function automatic logic [9:0] addr_of(input logic [2:0] oh);
    case (oh)
      3'b001:  return A0;
      3'b010:  return A1;
      3'b100:  return A2;
      default: return 10'h000;
    endcase
  endfunction

  // ROM models: contents are rom_f(addr), read latency 1 and 3.
  always_ff @(posedge clk) begin
    if (rom_en_def) dout_def <= rom_f(rom_addr_def);
    if (rom_en_rr) dout_rr <= rom_f(rom_addr_rr);
    if (rom_en_l3) pipe_l3[0] <= rom_f(rom_addr_l3);
    pipe_l3[1] <= pipe_l3[0];
    pipe_l3[2] <= pipe_l3[1];
  end
  assign dout_l3 = pipe_l3[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 3'b111;
    req_addr = {A2, A1, A0};

    // Hand-derived grant sequences with req=111 held from reset release.
    // Default mask: req0 wins 15 times, then promoted req1, then promoted req2.
    for (int c = 0; c < 18; c++) begin
      exp_def[c] = (c < 15) ? 3'b001 : (c == 15) ? 3'b010 : (c == 16) ? 3'b100 : 3'b001;
    end
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
               3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reset held with all requests up.
    tick(); tick(); tick();
    settle();
    chk("rst_gnt_def", 32'(gnt_def), 32'h0);
    chk("rst_gnt_rr", 32'(gnt_rr), 32'h0);
    chk("rst_rvalid", 32'(rvalid_def), 32'h0);
    chk("rst_rdata", 32'(rdata_def), 32'h0);
    chk("rst_rom_en", 32'(rom_en_def), 32'h0);

    // Release and hold req=111: round-robin, priority and starvation together.
    for (int c = 0; c < 18; c++) begin
      tick();
      if (c == 0) rst_n = 1'b1;
      settle();
      chk("seq_gnt_def", 32'(gnt_def), 32'(exp_def[c]));
      chk("seq_gnt_rr", 32'(gnt_rr), 32'(exp_rr[c]));
      if (c == 0) begin
        chk("seq_rom_en0", 32'(rom_en_def), 32'h0);
      end else begin
        chk("seq_rom_en", 32'(rom_en_def), 32'h1);
        chk("seq_rom_addr", 32'(rom_addr_def), 32'(addr_of(exp_def[c-1])));
      end
      if (c >= 3) begin
        chk("seq_rvalid_def", 32'(rvalid_def), 32'(exp_def[c-3]));
        chk("seq_rdata_def", 32'(rdata_def), 32'(rom_f(addr_of(exp_def[c-3]))));
        chk("seq_rvalid_rr", 32'(rvalid_rr), 32'(exp_rr[c-3]));
        chk("seq_rdata_rr", 32'(rdata_rr), 32'(rom_f(addr_of(exp_rr[c-3]))));
      end else begin
        chk("seq_rvalid_def0", 32'(rvalid_def), 32'h0);
        chk("seq_rvalid_rr0", 32'(rvalid_rr), 32'h0);
      end
      if (c >= 5) begin
        chk("seq_rvalid_l3", 32'(rvalid_l3), 32'(exp_def[c-5]));
        chk("seq_rdata_l3", 32'(rdata_l3), 32'(rom_f(addr_of(exp_def[c-5]))));
      end else begin
        chk("seq_rvalid_l3_0", 32'(rvalid_l3), 32'h0);
      end
    end

    // Idle: rom_en drops after a no-grant cycle, rom_addr holds.
    tick(); req = 3'b000; settle();
    chk("idle_gnt", 32'(gnt_def), 32'h0);
    chk("idle_rom_en1", 32'(rom_en_def), 32'h1);
    tick(); settle();
    chk("idle_rom_en0", 32'(rom_en_def), 32'h0);
    chk("idle_rom_addr", 32'(rom_addr_def), 32'(A0));
    tick(); tick(); tick(); tick();

    // Latency: single request from requester 1.
    tick(); req = 3'b010; settle();
    chk("lat_gnt_T", 32'(gnt_def), 32'h2);
    tick(); req = 3'b000; settle();
    chk("lat_rom_en_T1", 32'(rom_en_def), 32'h1);
    chk("lat_rom_addr_T1", 32'(rom_addr_def), 32'h05A);
    chk("lat_gnt_T1", 32'(gnt_def), 32'h0);
    tick(); settle();
    chk("lat_rvalid_T2", 32'(rvalid_def), 32'h0);
    chk("lat_rom_en_T2", 32'(rom_en_def), 32'h0);
    tick(); settle();
    chk("lat_rvalid_T3", 32'(rvalid_def), 32'h2);
    chk("lat_rdata_T3", 32'(rdata_def), 32'hC3);
    chk("lat_l3_rvalid_T3", 32'(rvalid_l3), 32'h0);
    tick(); settle();
    chk("lat_rvalid_T4", 32'(rvalid_def), 32'h0);
    chk("lat_rdata_hold", 32'(rdata_def), 32'hC3);
    chk("lat_l3_rvalid_T4", 32'(rvalid_l3), 32'h0);
    tick(); settle();
    chk("lat_l3_rvalid_T5", 32'(rvalid_l3), 32'h2);
    chk("lat_l3_rdata_T5", 32'(rdata_l3), 32'hC3);
    tick(); settle();
    chk("lat_l3_rvalid_T6", 32'(rvalid_l3), 32'h0);

    // Withdraw: req2 loses to req0, then drops before being granted.
    tick(); req = 3'b101; settle();
    chk("wd_gnt_A", 32'(gnt_def), 32'h1);
    tick(); req = 3'b000; settle();
    chk("wd_gnt_B", 32'(gnt_def), 32'h0);
    tick(); tick(); settle();
    chk("wd_rvalid_A3", 32'(rvalid_def), 32'h1);
    chk("wd_rdata_A3", 32'(rdata_def), 32'h88);
    tick(); settle();
    chk("wd_rvalid_A4", 32'(rvalid_def), 32'h0);

    // Reset one cycle after a grant flushes the in-flight read.
    tick(); req = 3'b010; settle();
    chk("fl_gnt_T", 32'(gnt_def), 32'h2);
    chk("fl_gnt_rr_T", 32'(gnt_rr), 32'h2);
    tick(); rst_n = 1'b0; req = 3'b000; settle();
    chk("fl_rom_en_T1", 32'(rom_en_def), 32'h1);
    tick(); rst_n = 1'b1; settle();
    chk("fl_rom_en_T2", 32'(rom_en_def), 32'h0);
    chk("fl_rom_addr_T2", 32'(rom_addr_def), 32'h0);
    tick(); req = 3'b110; settle();
    chk("fl_rvalid_T3", 32'(rvalid_def), 32'h0);
    chk("fl_rdata_T3", 32'(rdata_def), 32'h0);
    chk("fl_ptr_reset_rr", 32'(gnt_rr), 32'h2);
    tick(); req = 3'b000; settle();
    chk("fl_l3_rvalid_T4", 32'(rvalid_l3), 32'h0);
    tick(); settle();
    chk("fl_l3_rvalid_T5", 32'(rvalid_l3), 32'h0);
    chk("fl_l3_rdata_T5", 32'(rdata_l3), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_rom_arbiter.md
Name: tile_rom_arbiter

Overview:
- Shares one single-port tile/sprite colour ROM between several pixel-path requesters: grass tiles, animated flower tiles and player sprite.
- Each request is one ROM word. The block grants one requester per clock, drives the ROM address, and returns the 8-bit colour tagged to the winner.
- Arbitration is round-robin, with a strict-priority class for the scan-critical background path and starvation promotion for low-priority requesters.
- Sits between the background/sprite renderers and the shared ROM, clocked at pixel clock.

Parameters:
- NREQ, 3, number of requesters (2..8).
- ADDR_W, 10, ROM address width.
- DATA_W, 8, ROM word width (RGB332 colour).
- ROM_LAT, 1, ROM read latency in cycles, from rom_addr registered to rom_dout valid (1..3).
- HIPRI_MASK, 3'b001, requesters whose bit is set form the high-priority class.
- STARVE_MAX, 15, wait cycles after which a pending low-priority requester is promoted.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- req  in  NREQ  per-requester request level
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- gnt  out  NREQ  one-hot grant, combinational, same cycle as winning req
- rom_en  out  1  registered ROM enable
- rom_addr  out  ADDR_W  registered ROM address
- rom_dout  in  DATA_W  ROM read data
- rvalid  out  NREQ  one-hot, marks the owner of rdata
- rdata  out  DATA_W  registered read data

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - gnt=0, rom_en=0, rom_addr=0, rvalid=0, rdata=0.
  - rr_ptr=0.
  - All starvation counters = 0.
  - Latency pipeline tags invalid.
  - Reset mid-operation drops every in-flight read; no rvalid is ever produced for a grant issued before reset.
- Request rules:
  - A requester holds req=1 and a stable req_addr until it sees gnt in the same cycle.
  - If req stays high the next cycle, that is a new request.
  - Dropping req before grant withdraws the request; no error.
- Arbitration each cycle, on eligible = req:
  - Class order: promoted, then high-priority, then low-priority. The highest non-empty class wins.
  - Within a class, round-robin: search starts at rr_ptr and wraps modulo NREQ.
  - At most one gnt bit is set. gnt=0 when req=0.
- rr_ptr update:
  - On any grant to index k, rr_ptr <= (k+1) mod NREQ. This is a single shared pointer for all classes.
  - rr_ptr holds when there is no grant.
- Starvation, per low-priority requester i:
  - cnt_i <= 0 when req_i=0 or gnt_i=1.
  - Otherwise cnt_i increments, saturating at STARVE_MAX.
  - Requester i is promoted while cnt_i == STARVE_MAX.
  - High-priority requesters have no counter.
  - Multiple promoted requesters share round-robin among themselves.
- Datapath timing (T = grant cycle):
  - T+1: rom_en=1, rom_addr = winner's req_addr captured at T.
  - T+1+ROM_LAT: rom_dout valid.
  - T+2+ROM_LAT: rdata = rom_dout, rvalid = one-hot of winner.
  - Total latency from gnt to rvalid is 2+ROM_LAT cycles (3 at default).
- rom_en=0 in cycles following a no-grant cycle. rom_addr then holds its last value.
- Throughput: one grant per cycle sustained. A tag shift register of depth 1+ROM_LAT carries a valid bit plus winner index.
- rvalid is a single-cycle pulse per grant. rdata holds its value when rvalid=0.
- Back-to-back grants to the same requester are legal, e.g. when it is the sole requester.
- Widths: all index arithmetic uses clog2(NREQ) bits; wrap is explicit modulo NREQ, not natural overflow.

Decomposition:
- Shared package holds:
  - RGB332 colour type.
  - Screen/tile constants: tile size 8, active window h 144..783, v 31..510.
  - Index-width helper function.
- One sub-module, rr_pick: a combinational round-robin picker that takes a mask and a pointer and returns a one-hot result plus a found flag.
- rr_pick is instantiated three times, once per class. The top level selects the highest non-empty class.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req=3'b111 -> gnt=0, rvalid=0, rdata=0. First grant after release goes to index 0.
- Latency: only req[1]=1, addr=10'h05A, rom model returns 8'hC3 for 10'h05A:
  - gnt=3'b010 at T.
  - rom_addr=10'h05A with rom_en=1 at T+1.
  - rvalid=3'b010, rdata=8'hC3 at T+3.
- Round-robin: HIPRI_MASK=0, req=3'b111 held for 6 cycles -> gnt sequence 001, 010, 100, 001, 010, 100. The rvalid sequence is identical, delayed 3 cycles.
- Priority and starvation: default mask, req=3'b111 held continuously:
  - req0 wins every cycle until req1 counter reaches 15.
  - Then gnt=3'b010 for one cycle, and req1 counter resets.
  - req2 is promoted on the same cycle as req1 and is granted next.
- Withdraw and reset flush:
  - req[2] asserted then dropped before grant -> no gnt, no rvalid.
  - Separately, rst_n=0 one cycle after a grant -> no rvalid appears at T+3.
- ROM_LAT=3 build: single request -> rvalid at T+5, with the correct data.
